// File: rtl/step_counter_pkg.sv
// Shared types and helpers for the step counter: output encoding select,
// Gray/binary conversion and the divider range check.
package step_counter_pkg;

    typedef enum logic {
        CODE_GRAY = 1'b0,
        CODE_BIN  = 1'b1
    } code_mode_e;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic int calc_div(input int clkHz, input int stepHz);
        return (stepHz > 0) ? (clkHz / stepHz) : 0;
    endfunction

    function automatic bit div_ok(input int clkHz, input int stepHz);
        return calc_div(clkHz, stepHz) >= 2;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Rate divider: one-cycle tick every DIV clocks, held at zero while cleared.
module tick_gen
    import step_counter_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int STEP_FREQ_HZ = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, STEP_FREQ_HZ);
    localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (!div_ok(CLK_FREQ_HZ, STEP_FREQ_HZ)) begin : g_bad_div
            $error("tick_gen: CLK_FREQ_HZ/STEP_FREQ_HZ must be at least 2");
        end
    endgenerate

    logic [DW-1:0] r_div;
    logic          w_atEnd;

    assign w_atEnd = (r_div == DW'(DIV - 1));
    assign o_tick  = w_atEnd & ~i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (i_clr || w_atEnd) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Up/down step counter with Gray or binary output, wrap/saturate, load and
// terminal-count flag; steps come from the rate divider or a manual input.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int STEP_FREQ_HZ = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_man_clk,
    input  logic             i_man_clk_en,
    input  logic             i_dir,
    input  logic             i_mode,
    input  logic             i_sat,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_code,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_step,
    output logic             o_tc
);

    generate
        if (WIDTH < 2 || SYNC_STAGES < 2) begin : g_bad_param
            $error("step_counter: WIDTH and SYNC_STAGES must be at least 2");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edgeHist;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_code;
    logic                   r_step;
    logic                   r_tc;

    logic                   w_manEdge;
    logic                   w_tick;
    logic                   w_stepReq;
    logic                   w_atTerm;
    logic [WIDTH-1:0]       w_cntNext;
    logic [WIDTH-1:0]       w_codeNext;
    logic                   w_stepNext;
    logic                   w_tcNext;

    tick_gen #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .STEP_FREQ_HZ (STEP_FREQ_HZ)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_man_clk_en),
        .o_tick (w_tick)
    );

    // The edge register follows the last synchroniser stage, so a button
    // already held high when manual mode is entered does not count as a step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync     <= '0;
            r_edgeHist <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_man_clk};
            r_edgeHist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_manEdge = r_sync[SYNC_STAGES-1] & ~r_edgeHist;
    assign w_stepReq = i_man_clk_en ? w_manEdge : w_tick;

    always_comb begin
        w_cntNext  = r_cnt;
        w_stepNext = 1'b0;
        w_tcNext   = 1'b0;
        w_atTerm   = i_dir ? (r_cnt == '0) : (r_cnt == MAX_VAL);
        if (i_load) begin
            w_cntNext = i_load_val;
        end else if (w_stepReq) begin
            w_stepNext = 1'b1;
            if (w_atTerm) begin
                w_tcNext = 1'b1;
                if (!i_sat) begin
                    w_cntNext = i_dir ? MAX_VAL : '0;
                end
            end else begin
                w_cntNext = i_dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
            end
        end
    end

    // Encoding is taken from the next-state count so o_code and o_bin move together.
    assign w_codeNext = (code_mode_e'(i_mode) == CODE_BIN)
                        ? w_cntNext
                        : WIDTH'(bin2gray(MAX_W'(w_cntNext)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_code <= '0;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_cnt  <= w_cntNext;
            r_code <= w_codeNext;
            r_step <= w_stepNext;
            r_tc   <= w_tcNext;
        end
    end

    assign o_bin  = r_cnt;
    assign o_code = r_code;
    assign o_step = r_step;
    assign o_tc   = r_tc;

endmodule
